results_framer: RTL and testbench



---
 rtl/master_pkg.sv | 22 ++
 rtl/results_framer_if.sv | 28 ++
 rtl/uart_tx_handshake.sv | 50 +++++
 rtl/results_framer.sv | 141 ++++++++++++++
 tb/tb_results_framer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/master_pkg.sv
// Shared definitions for the result framer: state names, default sync byte
// and the frame-length helper used to size the byte counter.
package master_pkg;

  // IDLE/LOAD/WAIT/DONE sequence the frame; PULSE/HOLD/WAIT pace each byte.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    HOLD,
    WAIT,
    DONE
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Sync byte + sequence byte + payload + checksum byte.
  function automatic int frame_len(input int n_ch, input int sum_w);
    return 3 + (n_ch * sum_w) / 8;
  endfunction

endpackage

// File: rtl/results_framer_if.sv
// Bundle of the framer's control, accumulator and UART-side signals.
// The slave modport is the framer; the master modport is its environment
// (master FSM, correlator sums and UART transmitter).
interface results_framer_if #(
  parameter int N_CH  = 6,
  parameter int SUM_W = 64
);

  logic                    send_start;
  logic [N_CH*SUM_W-1:0]   sums;
  logic                    uart_busy;
  logic                    send_busy;
  logic                    tx_start;
  logic [7:0]              tx_byte;
  logic [7:0]              frame_seq;
  logic                    frame_done;

  modport master (
    output send_start, sums, uart_busy,
    input  send_busy, tx_start, tx_byte, frame_seq, frame_done
  );

  modport slave (
    input  send_start, sums, uart_busy,
    output send_busy, tx_start, tx_byte, frame_seq, frame_done
  );

endinterface

// File: rtl/uart_tx_handshake.sv
// Per-byte pacing towards the UART: one tx_start pulse, one cycle in which
// uart_busy is not trusted yet (the UART may raise it a cycle late), then
// wait for the transmitter to go idle and acknowledge the byte.
module uart_tx_handshake
  import master_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic byte_req,
  input  logic uart_busy,
  output logic tx_start,
  output logic byte_ack
);

  frame_state_e state_q, state_d;

  // State register for the byte handshake.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and outputs; a request coinciding with an ack chains straight
  // into the next PULSE so back-to-back bytes cost three cycles each.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    byte_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_req) state_d = PULSE;
      end
      PULSE: begin
        tx_start = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!uart_busy) begin
          byte_ack = 1'b1;
          state_d  = byte_req ? PULSE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/results_framer.sv
// Snapshots N_CH accumulators and streams them to the UART as one frame:
// sync byte, sequence number, payload (channel 0 first, MSB byte first),
// and an XOR checksum over the sequence and payload bytes.
module results_framer
  import master_pkg::*;
#(
  parameter int         N_CH      = 6,
  parameter int         SUM_W     = 64,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic             sys_clk,
  input logic             sys_rst,
  results_framer_if.slave bus
);

  localparam int NB    = (N_CH * SUM_W) / 8;
  localparam int BPC   = SUM_W / 8;
  localparam int L     = frame_len(N_CH, SUM_W);
  localparam int CNT_W = $clog2(L);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(L - 2);

  if ((SUM_W % 8) != 0 || SUM_W < 8 || SUM_W > 64) begin : g_bad_sum_w
    $error("results_framer: SUM_W must be a multiple of 8 in 8..64");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("results_framer: N_CH must be in 1..16");
  end

  frame_state_e         state_q, state_d;
  logic [NB*8-1:0]      payload_q, payload_d;
  logic [7:0]           csum_q, csum_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [7:0]           seq_q, seq_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [NB*8-1:0]      ordered;
  logic [7:0]           next_byte;
  logic                 byte_req;
  logic                 byte_ack;
  logic                 tx_start;

  // Rearrange the accumulator bus into transmit order so the snapshot can be
  // emptied by shifting the top byte out.
  always_comb begin
    ordered = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      for (int b = 0; b < BPC; b++) begin
        ordered[(NB - 1 - (ch * BPC + b)) * 8 +: 8] =
          bus.sums[ch * SUM_W + (BPC - 1 - b) * 8 +: 8];
      end
    end
  end

  // Frame registers; a reset abandons any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      payload_q <= '0;
      csum_q    <= '0;
      tx_byte_q <= '0;
      seq_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      csum_q    <= csum_d;
      tx_byte_q <= tx_byte_d;
      seq_q     <= seq_d;
      idx_q     <= idx_d;
    end
  end

  // Frame sequencing; idx_q is the index of the byte most recently issued.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    csum_d    = csum_q;
    tx_byte_d = tx_byte_q;
    seq_d     = seq_q;
    idx_d     = idx_q;
    byte_req  = 1'b0;
    next_byte = 8'h00;
    case (state_q)
      IDLE: begin
        if (bus.send_start) begin
          payload_d = ordered;
          csum_d    = '0;
          idx_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        byte_req  = 1'b1;
        tx_byte_d = SYNC_BYTE;
        idx_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (byte_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            byte_req = 1'b1;
            idx_d    = idx_q + CNT_W'(1);
            if (idx_q == '0) begin
              next_byte = seq_q;
            end else if (idx_q == PAY_LAST) begin
              next_byte = csum_q;
            end else begin
              next_byte = payload_q[NB*8-1 -: 8];
              payload_d = payload_q << 8;
            end
            tx_byte_d = next_byte;
            if (idx_q != PAY_LAST) csum_d = csum_q ^ next_byte;
          end
        end
      end
      DONE: begin
        seq_d   = seq_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_tx_handshake u_handshake (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .byte_req  (byte_req),
    .uart_busy (bus.uart_busy),
    .tx_start  (tx_start),
    .byte_ack  (byte_ack)
  );

  assign bus.send_busy  = (state_q != IDLE);
  assign bus.tx_start   = tx_start;
  assign bus.tx_byte    = tx_byte_q;
  assign bus.frame_seq  = seq_q;
  assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_results_framer.sv
// Bench for results_framer: three instances (6x64, 2x16, 1x8), each with a
// simple UART busy model. Expected frames are built from the accumulator
// values and queued when a frame is requested; per-instance monitors pop and
// compare every byte the framer hands to the UART.
module tb_results_framer;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  always #5 sys_clk = ~sys_clk;

  logic [2:0]            start_v;
  logic [2:0][383:0]     sums_v;
  int                    busy_len [3];
  logic [2:0]            send_busy_w, tx_start_w, frame_done_w;
  logic [2:0][7:0]       tx_byte_w, frame_seq_w;

  logic [7:0]            exp_q [3][$];
  int                    done_seen [3];
  int                    exp_done [3];
  logic [7:0]            model_seq [3];

  int vectors     = 0;
  int miscompares = 0;

  function automatic int nch_of(input int g);
    return (g == 0) ? 6 : ((g == 1) ? 2 : 1);
  endfunction

  function automatic int sw_of(input int g);
    return (g == 0) ? 64 : ((g == 1) ? 16 : 8);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NCH = (g == 0) ? 6 : ((g == 1) ? 2 : 1);
    localparam int SW  = (g == 0) ? 64 : ((g == 1) ? 16 : 8);

    int bcnt;
    logic [7:0] exp_b;

    results_framer_if #(.N_CH(NCH), .SUM_W(SW)) bus ();

    assign bus.send_start  = start_v[g];
    assign bus.sums        = sums_v[g][NCH*SW-1:0];
    assign bus.uart_busy   = (bcnt != 0);
    assign send_busy_w[g]  = bus.send_busy;
    assign tx_start_w[g]   = bus.tx_start;
    assign tx_byte_w[g]    = bus.tx_byte;
    assign frame_seq_w[g]  = bus.frame_seq;
    assign frame_done_w[g] = bus.frame_done;

    results_framer #(.N_CH(NCH), .SUM_W(SW), .SYNC_BYTE(8'hA5)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
    );

    // UART model: busy for busy_len cycles starting the cycle after tx_start.
    always @(posedge sys_clk) begin
      if (sys_rst)                            bcnt <= 0;
      else if (bus.tx_start && busy_len[g] > 0) bcnt <= busy_len[g];
      else if (bcnt > 0)                      bcnt <= bcnt - 1;
    end

    // Monitor: every byte offered to the UART must be the next expected one.
    always @(negedge sys_clk) begin
      if (tx_start_w[g]) begin
        if (exp_q[g].size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL inst%0d_unexpected_byte: got %0h, expected none",
                   g, tx_byte_w[g]);
        end else begin
          exp_b = exp_q[g].pop_front();
          check_output($sformatf("inst%0d_byte", g), 32'(tx_byte_w[g]), 32'(exp_b));
        end
      end
      if (frame_done_w[g]) done_seen[g]++;
    end
  end

  function automatic logic [383:0] rand_sums();
    logic [383:0] s;
    for (int i = 0; i < 12; i++) s[i*32 +: 32] = $urandom();
    return s;
  endfunction

  // Reference frame: sync, sequence, channels 0..N-1 MSB byte first, XOR sum.
  task automatic push_frame(input int g, input logic [383:0] s);
    int nch, sw;
    logic [7:0] cs, b8;
    nch = nch_of(g);
    sw  = sw_of(g);
    exp_q[g].push_back(8'hA5);
    exp_q[g].push_back(model_seq[g]);
    cs = model_seq[g];
    for (int ch = 0; ch < nch; ch++) begin
      for (int b = sw / 8 - 1; b >= 0; b--) begin
        b8 = s[ch*sw + b*8 +: 8];
        exp_q[g].push_back(b8);
        cs = cs ^ b8;
      end
    end
    exp_q[g].push_back(cs);
    exp_done[g]++;
    model_seq[g] = model_seq[g] + 8'd1;
  endtask

  // Request one frame from an idle framer; returns at the LOAD-cycle negedge.
  task automatic apply_stimulus(input int g, input logic [383:0] s);
    for (int i = 0; i < 20000 && send_busy_w[g]; i++) @(negedge sys_clk);
    check_output($sformatf("inst%0d_idle_before_start", g), 32'(send_busy_w[g]), 32'd0);
    sums_v[g] = s;
    push_frame(g, s);
    start_v[g] = 1'b1;
    @(negedge sys_clk);
    start_v[g] = 1'b0;
    check_output($sformatf("inst%0d_load_busy", g), 32'(send_busy_w[g]), 32'd1);
    check_output($sformatf("inst%0d_load_no_tx", g), 32'(tx_start_w[g]), 32'd0);
  endtask

  // Follow the frame to completion, checking first-byte latency, total busy
  // time, a single done pulse and the advanced sequence number. With perturb
  // set the sums change and send_start pulses while the frame is in flight.
  task automatic finish_frame(input int g, input bit perturb);
    int cyc, dones, len, per, exp_cyc;
    bit ended;
    cyc   = 1;
    dones = 0;
    ended = 1'b0;
    len   = 3 + nch_of(g) * sw_of(g) / 8;
    per   = 2 + ((busy_len[g] > 1) ? busy_len[g] : 1);
    exp_cyc = 2 + len * per;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sys_clk);
      if (cyc == 1) begin
        check_output($sformatf("inst%0d_first_tx_start", g), 32'(tx_start_w[g]), 32'd1);
        check_output($sformatf("inst%0d_first_byte", g), 32'(tx_byte_w[g]), 32'hA5);
      end
      if (perturb && cyc == 4) begin
        sums_v[g]  = rand_sums();
        start_v[g] = 1'b1;
      end
      if (cyc == 5) start_v[g] = 1'b0;
      if (frame_done_w[g] && send_busy_w[g]) dones++;
      if (!send_busy_w[g]) begin
        ended = 1'b1;
        break;
      end
      cyc++;
    end
    start_v[g] = 1'b0;
    check_output($sformatf("inst%0d_frame_ended", g), 32'(ended), 32'd1);
    check_output($sformatf("inst%0d_frame_cycles", g), 32'(cyc), 32'(exp_cyc));
    check_output($sformatf("inst%0d_done_pulses", g), 32'(dones), 32'd1);
    check_output($sformatf("inst%0d_frame_seq", g), 32'(frame_seq_w[g]), 32'(model_seq[g]));
  endtask

  task automatic check_reset_state(input int g);
    check_output($sformatf("inst%0d_rst_send_busy", g), 32'(send_busy_w[g]), 32'd0);
    check_output($sformatf("inst%0d_rst_tx_start", g), 32'(tx_start_w[g]), 32'd0);
    check_output($sformatf("inst%0d_rst_tx_byte", g), 32'(tx_byte_w[g]), 32'd0);
    check_output($sformatf("inst%0d_rst_frame_seq", g), 32'(frame_seq_w[g]), 32'd0);
    check_output($sformatf("inst%0d_rst_frame_done", g), 32'(frame_done_w[g]), 32'd0);
  endtask

  initial begin
    int n;
    start_v = '0;
    sums_v  = '0;
    for (int g = 0; g < 3; g++) begin
      busy_len[g]  = 0;
      done_seen[g] = 0;
      exp_done[g]  = 0;
      model_seq[g] = 8'h00;
    end
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    for (int g = 0; g < 3; g++) check_reset_state(g);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Two-channel 16-bit frame with a slow UART: A5,00,12,34,AB,CD,40.
    busy_len[1] = 10;
    apply_stimulus(1, 384'({16'hABCD, 16'h1234}));
    finish_frame(1, 1'b0);
    check_output("inst1_seq_after_first", 32'(frame_seq_w[1]), 32'd1);

    // Same instance, random sums, disturbed mid-frame.
    busy_len[1] = 3;
    apply_stimulus(1, rand_sums());
    finish_frame(1, 1'b1);

    // Default geometry with the UART never busy, then with a short busy.
    busy_len[0] = 0;
    apply_stimulus(0, rand_sums());
    finish_frame(0, 1'b1);
    apply_stimulus(0, rand_sums());
    finish_frame(0, 1'b0);
    busy_len[0] = 2;
    apply_stimulus(0, rand_sums());
    finish_frame(0, 1'b1);

    // Single 8-bit channel: A5,00,5A,5A, then 256 more so the header wraps.
    busy_len[2] = 0;
    apply_stimulus(2, 384'(8'h5A));
    finish_frame(2, 1'b0);
    for (int f = 0; f < 256; f++) begin
      busy_len[2] = $urandom_range(0, 2);
      apply_stimulus(2, rand_sums());
      finish_frame(2, 1'b0);
    end
    check_output("inst2_seq_after_wrap", 32'(frame_seq_w[2]), 32'd1);

    // Reset while the fourth byte is being handed to the UART.
    busy_len[0] = $urandom_range(0, 3);
    apply_stimulus(0, rand_sums());
    n = 0;
    for (int i = 0; i < 5000 && n < 4; i++) begin
      @(negedge sys_clk);
      if (tx_start_w[0]) n++;
    end
    check_output("inst0_reached_byte4", 32'(n), 32'd4);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_output("inst0_midrst_send_busy", 32'(send_busy_w[0]), 32'd0);
    check_output("inst0_midrst_tx_start", 32'(tx_start_w[0]), 32'd0);
    check_output("inst0_midrst_frame_seq", 32'(frame_seq_w[0]), 32'd0);
    exp_q[0].delete();
    exp_done[0]--;
    for (int g = 0; g < 3; g++) model_seq[g] = 8'h00;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_output("inst0_no_done_after_rst", 32'(done_seen[0]), 32'(exp_done[0]));

    // A full frame after the abort starts again at sequence 00.
    apply_stimulus(0, rand_sums());
    finish_frame(0, 1'b0);

    @(negedge sys_clk);
    for (int g = 0; g < 3; g++) begin
      check_output($sformatf("inst%0d_queue_drained", g), 32'(exp_q[g].size()), 32'd0);
      check_output($sformatf("inst%0d_done_count", g), 32'(done_seen[g]), 32'(exp_done[g]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
